// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared types and constants for the memory request master.
//   state_e    : FSM state encoding. 3 bits so that the read-back verify states
//                fit in the same encoding.
//   *_DEF      : default width and timeout constants.
//   tmr_width  : timeout counter width, $clog2(TIMEOUT+1).
// Optional feature macro: MEM_MASTER_VERIFY_EN adds ST_VREAD / ST_VWAIT.
package mem_master_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 6;
  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned TIMEOUT_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
`ifdef MEM_MASTER_VERIFY_EN
    ST_RESP  = 3'd4,
    ST_VREAD = 3'd5,
    ST_VWAIT = 3'd6
`else
    ST_RESP  = 3'd4
`endif
  } state_e;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int unsigned tmr_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_master_tmr.sv
// mem_master_tmr: WAIT-state timeout counter.
//   clk, RESET_L : clock, async active-low reset
//   clr          : zero the counter (takes priority over inc)
//   inc          : advance the counter by one
//   expire_c     : combinational, high while the current WAIT cycle is the
//                  TIMEOUT-th one since the last clear
module mem_master_tmr
  import mem_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic RESET_L,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  localparam int unsigned CNT_W = tmr_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed empty WAIT cycles, so the current cycle is the last
  // allowed one when TIMEOUT-1 of them have already elapsed.
  assign expire_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_master.sv
// mem_master: request-side controller for the single-port synchronous memory.
//   clk, RESET_L               : clock, async active-low reset
//   req_valid/req_ready        : upstream request handshake
//   req_write/req_addr/req_data: request payload, latched on accept
//   mem_address/mem_data       : latched request to memory
//   mem_write/mem_read         : one-cycle memory strobes, never both high
//   mem_data_in/mem_valid/mem_err : memory return path
//   rsp_valid/rsp_data/rsp_err : one-cycle response strobe and payload
// All outputs are flops. Optional macro MEM_MASTER_VERIFY_EN adds a
// read-back compare after every write (WRITE -> VREAD -> VWAIT -> RESP).
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_valid,
  input  logic                  mem_err,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_ready_q, req_ready_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  tmr_clr;
  logic                  tmr_inc;
  logic                  tmr_expire_c;

  mem_master_tmr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk      (clk),
    .RESET_L  (RESET_L),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .expire_c (tmr_expire_c)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;

    // Sticky until the next accept clears it.
    if ((state_q != ST_IDLE) && mem_err) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_data;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
`ifdef MEM_MASTER_VERIFY_EN
        state_d = ST_VREAD;
`else
        state_d = ST_RESP;
`endif
      end
      ST_READ: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          rdata_d = mem_data_in;
          state_d = ST_RESP;
        end else if (tmr_expire_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
`ifdef MEM_MASTER_VERIFY_EN
      ST_VREAD: begin
        tmr_clr = 1'b1;
        state_d = ST_VWAIT;
      end
      ST_VWAIT: begin
        if (mem_valid) begin
          rdata_d = mem_data_in;
          if (wr_q && (mem_data_in != wdata_q)) begin
            err_d = 1'b1;
          end
          state_d = ST_RESP;
        end else if (tmr_expire_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
`endif
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state.
    req_ready_d = (state_d == ST_IDLE);
    mem_write_d = (state_d == ST_WRITE);
`ifdef MEM_MASTER_VERIFY_EN
    mem_read_d  = (state_d == ST_READ) || (state_d == ST_VREAD);
    rsp_data_d  = (state_d == ST_RESP) ? rdata_d : '0;
`else
    mem_read_d  = (state_d == ST_READ);
    rsp_data_d  = ((state_d == ST_RESP) && !wr_d) ? rdata_d : '0;
`endif
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = (state_d == ST_RESP) && err_d;
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed self-checking bench for mem_master with a small
// behavioural memory (one-cycle read latency, optional stall and corruption).
module tb_mem_master;

  localparam int unsigned DW = 6;
  localparam int unsigned AW = 3;
  localparam int unsigned TO = 4;

`ifdef MEM_MASTER_VERIFY_EN
  localparam int WR_LAT = 2;
  localparam bit WR_RET_DATA = 1'b1;
`else
  localparam int WR_LAT = 0;
  localparam bit WR_RET_DATA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESET_L;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_data_in;
  logic          mem_valid;
  logic          mem_err;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  logic [DW-1:0] mem [1<<AW];
  logic          stall;
  logic          corrupt;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .RESET_L     (RESET_L),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_data_in (mem_data_in),
    .mem_valid   (mem_valid),
    .mem_err     (mem_err),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  // Memory model: write on strobe, read data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= corrupt ? 6'h15 : mem_data;
    if (mem_read && !stall) begin
      mem_valid   <= 1'b1;
      mem_data_in <= mem[mem_address];
    end else begin
      mem_valid   <= 1'b0;
      mem_data_in <= '0;
    end
  end

  // Strobes must never overlap.
  always @(negedge clk) begin
    if (RESET_L === 1'b1) begin
      n_cmp++;
      assert (!(mem_write && mem_read)) else begin
        n_fail++;
        $error("FAIL strobe_excl: observed write=%0b read=%0b expected not both", mem_write, mem_read);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count negedges until rsp_valid; n is the number of cycles without it.
  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      @(negedge clk);
      if (!rsp_valid) n++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_wstb"}, 32'(mem_write), 32'd1);
    check({tag, "_waddr"}, 32'(mem_address), 32'(a));
    check({tag, "_wdata"}, 32'(mem_data), 32'(d));
    wait_rsp(20, n);
    check({tag, "_wlat"}, 32'(n), 32'(WR_LAT));
    check({tag, "_werr"}, 32'(rsp_err), 32'd0);
    check({tag, "_wrsp"}, 32'(rsp_data), WR_RET_DATA ? 32'(d) : 32'd0);
    @(negedge clk);
    check({tag, "_wdrop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                         input logic exp_e, input int exp_wait, input string tag);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_data = '0;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_rstb"}, 32'(mem_read), 32'd1);
    check({tag, "_raddr"}, 32'(mem_address), 32'(a));
    wait_rsp(20, n);
    check({tag, "_rwait"}, 32'(n), 32'(exp_wait));
    check({tag, "_rdata"}, 32'(rsp_data), 32'(exp_d));
    check({tag, "_rerr"}, 32'(rsp_err), 32'(exp_e));
    @(negedge clk);
    check({tag, "_rdrop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    RESET_L = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; mem_err = 1'b0;
    stall = 1'b0; corrupt = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outs", {mem_write, mem_read, rsp_valid, rsp_err}, 32'd0);
    check("rst_bus", {mem_address, mem_data, rsp_data}, 32'd0);
    RESET_L = 1'b1;

    // Write addr 3 data 0x2A, cycle by cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd3; req_data = 6'h2A;
    @(negedge clk);
    req_valid = 1'b0;
    check("w1_stb", 32'(mem_write), 32'd1);
    check("w1_addr", 32'(mem_address), 32'd3);
    check("w1_data", 32'(mem_data), 32'h2A);
    check("w1_busy", 32'(req_ready), 32'd0);
    check("w1_norsp", 32'(rsp_valid), 32'd0);
`ifdef MEM_MASTER_VERIFY_EN
    @(negedge clk);
    check("w1_vrd", {mem_write, mem_read}, 32'b01);
    @(negedge clk);
    check("w1_vwait", {mem_write, mem_read, rsp_valid}, 32'b000);
`endif
    @(negedge clk);
    check("w1_stb_off", 32'(mem_write), 32'd0);
    check("w1_rsp", 32'(rsp_valid), 32'd1);
    check("w1_err", 32'(rsp_err), 32'd0);
    check("w1_rdata", 32'(rsp_data), WR_RET_DATA ? 32'h2A : 32'd0);
    @(negedge clk);
    check("w1_done", {rsp_valid, req_ready}, 32'b01);

    // Read-back addr 3, cycle by cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    check("r1_stb", {mem_write, mem_read}, 32'b01);
    check("r1_addr", 32'(mem_address), 32'd3);
    @(negedge clk);
    check("r1_wait", {mem_read, rsp_valid}, 32'b00);
    @(negedge clk);
    check("r1_rsp", 32'(rsp_valid), 32'd1);
    check("r1_data", 32'(rsp_data), 32'h2A);
    check("r1_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check("r1_done", {rsp_valid, req_ready}, 32'b01);

    // Write after a read: response data reflects the write, not the old read.
    do_write(3'd4, 6'h07, "w2");
    do_read(3'd4, 6'h07, 1'b0, 1, "r2");

    // Timeout: memory never answers.
    stall = 1'b1;
    do_read(3'd3, 6'h00, 1'b1, TO, "tmo");
    stall = 1'b0;

    // Memory error pulse in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_err = 1'b1;
    @(negedge clk);
    mem_err = 1'b0;
    check("merr_rsp", 32'(rsp_valid), 32'd1);
    check("merr_err", 32'(rsp_err), 32'd1);
    check("merr_data", 32'(rsp_data), 32'h2A);
    do_read(3'd3, 6'h2A, 1'b0, 1, "merr_clr");

    // Reset pulse during WAIT.
    stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mrst_pre", {req_ready, rsp_valid}, 32'b00);
    RESET_L = 1'b0;
    #1;
    check("mrst_ready", 32'(req_ready), 32'd1);
    check("mrst_outs", {mem_write, mem_read, rsp_valid, rsp_err}, 32'd0);
    check("mrst_bus", {mem_address, mem_data, rsp_data}, 32'd0);
    @(negedge clk);
    check("mrst_norsp", 32'(rsp_valid), 32'd0);
    RESET_L = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    check("mrst_norsp2", 32'(rsp_valid), 32'd0);
    do_write(3'd6, 6'h33, "post");
    do_read(3'd6, 6'h33, 1'b0, 1, "post");

`ifdef MEM_MASTER_VERIFY_EN
    // Read-back mismatch: memory stores 0x15 instead of 0x2A.
    begin
      int n;
      corrupt = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_data = 6'h2A;
      @(negedge clk);
      req_valid = 1'b0;
      check("vfy_wstb", 32'(mem_write), 32'd1);
      wait_rsp(20, n);
      check("vfy_lat", 32'(n), 32'd2);
      check("vfy_err", 32'(rsp_err), 32'd1);
      check("vfy_data", 32'(rsp_data), 32'h15);
      corrupt = 1'b0;
      @(negedge clk);
    end
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
